// File: rtl/jam_host.sv
// Host around a JAM engine: loads the 8x8 cost table and golden results, resets and runs the engine, then grades it.
// Cost lookup is combinational; LD_READY stays high for the whole LOAD phase and is low afterwards.
module jam_host #(
  parameter int TIMEOUT_CYC = 10000000,
  parameter int HOLD_CYC    = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        LD_VALID,
  output logic        LD_READY,
  input  logic [9:0]  LD_DATA,
  output logic        JAM_RST,
  input  logic [2:0]  W,
  input  logic [2:0]  J,
  output logic [6:0]  Cost,
  input  logic [3:0]  MatchCount,
  input  logic [9:0]  MinCost,
  input  logic        Valid,
  output logic        DONE,
  output logic        PASS,
  output logic        TIMEOUT,
  output logic [23:0] CYC_CNT
);

  typedef enum logic [1:0] {S_LOAD, S_RSTJ, S_RUN, S_DONE} state_t;

  localparam logic [23:0] TO_LIM    = 24'(TIMEOUT_CYC);
  localparam logic [23:0] HOLD_LAST = 24'(HOLD_CYC - 1);

  state_t      state;
  logic [6:0]  ld_idx;
  logic [6:0]  cost_mem [64];
  logic [9:0]  gold_min;
  logic [3:0]  gold_match;
  logic [23:0] hold_cnt;

  assign Cost = cost_mem[{W, J}];

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= S_LOAD;
      ld_idx     <= '0;
      for (int i = 0; i < 64; i++) cost_mem[i] <= '0;
      gold_min   <= '0;
      gold_match <= '0;
      hold_cnt   <= '0;
      LD_READY   <= 1'b1;
      JAM_RST    <= 1'b1;
      DONE       <= 1'b0;
      PASS       <= 1'b0;
      TIMEOUT    <= 1'b0;
      CYC_CNT    <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          // LD_READY is high throughout LOAD, so LD_VALID alone means accepted
          if (LD_VALID) begin
            if (ld_idx < 7'd64)       cost_mem[ld_idx[5:0]] <= LD_DATA[6:0];
            else if (ld_idx == 7'd64) gold_min              <= LD_DATA;
            else                      gold_match            <= LD_DATA[3:0];
            if (ld_idx == 7'd65) begin
              state    <= S_RSTJ;
              LD_READY <= 1'b0;
              ld_idx   <= '0;
              hold_cnt <= '0;
            end else begin
              ld_idx <= ld_idx + 7'd1;
            end
          end
        end
        S_RSTJ: begin
          if (hold_cnt == HOLD_LAST) begin
            state   <= S_RUN;
            JAM_RST <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 24'd1;
          end
        end
        S_RUN: begin
          CYC_CNT <= CYC_CNT + 24'd1;
          // a result arriving on the timeout edge still counts
          if (Valid) begin
            PASS    <= (MinCost == gold_min) && (MatchCount == gold_match);
            DONE    <= 1'b1;
            JAM_RST <= 1'b1;
            state   <= S_DONE;
          end else if (CYC_CNT + 24'd1 == TO_LIM) begin
            TIMEOUT <= 1'b1;
            PASS    <= 1'b0;
            DONE    <= 1'b1;
            JAM_RST <= 1'b1;
            state   <= S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jam_host.sv
// Directed bench for jam_host: run outcomes go through an expected-result queue, lookups and flags are checked inline.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_jam_host;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        LD_VALID = 1'b0;
  logic [9:0]  LD_DATA = '0;
  logic [2:0]  W = '0;
  logic [2:0]  J = '0;
  logic [3:0]  MatchCount = '0;
  logic [9:0]  MinCost = '0;
  logic        Valid = 1'b0;
  logic        LD_READY, JAM_RST, DONE, PASS, TIMEOUT;
  logic [6:0]  Cost;
  logic [23:0] CYC_CNT;

  typedef struct packed {
    logic        done;
    logic        pass;
    logic        timeout;
    logic [23:0] cyc;
  } res_t;

  res_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  jam_host #(.TIMEOUT_CYC(100), .HOLD_CYC(3)) dut (
    .CLK(CLK), .RST(RST), .LD_VALID(LD_VALID), .LD_READY(LD_READY), .LD_DATA(LD_DATA),
    .JAM_RST(JAM_RST), .W(W), .J(J), .Cost(Cost), .MatchCount(MatchCount),
    .MinCost(MinCost), .Valid(Valid), .DONE(DONE), .PASS(PASS), .TIMEOUT(TIMEOUT),
    .CYC_CNT(CYC_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic load_words(input int n, input bit toggle, input logic [9:0] gmin, input logic [3:0] gmatch);
    for (int k = 0; k < n; k++) begin
      if (toggle) begin
        LD_VALID = 1'b0;
        @(negedge CLK);
      end
      if (k < 64)       LD_DATA = 10'(k);
      else if (k == 64) LD_DATA = gmin;
      else              LD_DATA = {6'd0, gmatch};
      LD_VALID = 1'b1;
      if (k == 0) chk("ld_ready_load", LD_READY, 1);
      @(negedge CLK);
    end
    LD_VALID = 1'b0;
  endtask

  task automatic check_hold();
    int hold = 0;
    chk("ld_ready_rstj", LD_READY, 0);
    while (JAM_RST === 1'b1 && hold < 20) begin
      hold++;
      @(negedge CLK);
    end
    chk("jam_rst_hold_cycles", hold, 3);
  endtask

  task automatic run_stub(input int vedge, input logic [9:0] mn, input logic [3:0] mc, input res_t e);
    res_t x;
    exp_q.push_back(e);
    if (vedge > 0) begin
      for (int i = 1; i < vedge; i++) begin
        @(negedge CLK);
        if (i == 1) chk("cyc_first_edge", CYC_CNT, 1);
      end
      MinCost = mn;
      MatchCount = mc;
      Valid = 1'b1;
      @(negedge CLK);
      Valid = 1'b0;
    end else begin
      for (int i = 0; i < 200 && DONE !== 1'b1; i++) @(negedge CLK);
    end
    x = exp_q.pop_front();
    chk("done", DONE, x.done);
    chk("pass", PASS, x.pass);
    chk("timeout", TIMEOUT, x.timeout);
    chk("cyc_cnt", CYC_CNT, x.cyc);
    chk("jam_rst_done", JAM_RST, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    do_reset();
    W = 3'd5; J = 3'd3; #1;
    chk("rst_cost", Cost, 0);
    chk("rst_ld_ready", LD_READY, 1);
    chk("rst_jam_rst", JAM_RST, 1);
    chk("rst_done", DONE, 0);
    chk("rst_pass", PASS, 0);
    chk("rst_timeout", TIMEOUT, 0);
    chk("rst_cyc", CYC_CNT, 0);

    // full load, lookups, passing run on 5th RUN edge
    load_words(66, 1'b0, 10'd8, 4'd1);
    W = 3'd5; J = 3'd3; #1; chk("cost_5_3", Cost, 43);
    W = 3'd7; J = 3'd7; #1; chk("cost_7_7", Cost, 63);
    W = 3'd2; J = 3'd6; #1; chk("cost_2_6", Cost, 22);
    check_hold();
    run_stub(5, 10'd8, 4'd1, '{done: 1'b1, pass: 1'b1, timeout: 1'b0, cyc: 24'd5});
    // DONE must ignore further results
    MinCost = 10'd9; Valid = 1'b1;
    repeat (3) @(negedge CLK);
    Valid = 1'b0;
    chk("hold_pass", PASS, 1);
    chk("hold_cyc", CYC_CNT, 5);
    chk("hold_ld_ready", LD_READY, 0);

    // MinCost mismatch
    do_reset();
    load_words(66, 1'b0, 10'd8, 4'd1);
    check_hold();
    run_stub(5, 10'd9, 4'd1, '{done: 1'b1, pass: 1'b0, timeout: 1'b0, cyc: 24'd5});

    // MatchCount mismatch
    do_reset();
    load_words(66, 1'b0, 10'd8, 4'd1);
    check_hold();
    run_stub(3, 10'd8, 4'd2, '{done: 1'b1, pass: 1'b0, timeout: 1'b0, cyc: 24'd3});

    // timeout, no Valid ever
    do_reset();
    load_words(66, 1'b0, 10'd8, 4'd1);
    check_hold();
    run_stub(0, 10'd8, 4'd1, '{done: 1'b1, pass: 1'b0, timeout: 1'b1, cyc: 24'd100});

    // Valid on the timeout edge wins
    do_reset();
    load_words(66, 1'b0, 10'd8, 4'd1);
    check_hold();
    run_stub(100, 10'd8, 4'd1, '{done: 1'b1, pass: 1'b1, timeout: 1'b0, cyc: 24'd100});

    // reset mid-load with gapped LD_VALID wipes the table
    do_reset();
    load_words(30, 1'b1, 10'd8, 4'd1);
    do_reset();
    for (int w = 0; w < 8; w++) begin
      for (int j = 0; j < 8; j++) begin
        W = 3'(w); J = 3'(j); #1;
        chk("cost_cleared", Cost, 0);
      end
    end
    chk("ld_ready_after_rst", LD_READY, 1);
    chk("done_after_rst", DONE, 0);
    load_words(66, 1'b1, 10'd8, 4'd1);
    W = 3'd5; J = 3'd3; #1; chk("reload_cost_5_3", Cost, 43);
    W = 3'd0; J = 3'd1; #1; chk("reload_cost_0_1", Cost, 1);
    check_hold();
    run_stub(5, 10'd8, 4'd1, '{done: 1'b1, pass: 1'b1, timeout: 1'b0, cyc: 24'd5});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jam_host.md
JAM_HOST -- requirements
Module: jam_host

Interface
REQ-001 Parameter TIMEOUT_CYC, default 10000000: RUN-state cycles allowed before timeout (1..2^24-1).
REQ-002 Parameter HOLD_CYC, default 3: cycles JAM_RST is held high in RSTJ (>=1).
REQ-003 CLK  input  1  single clock, all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-low.
REQ-005 LD_VALID  input  1  load word present.
REQ-006 LD_READY  output  1  load word accepted on edge when LD_VALID&&LD_READY.
REQ-007 LD_DATA  input  10  load word.
REQ-008 JAM_RST  output  1  active-high reset driven to the JAM engine.
REQ-009 W  input  3  worker index from JAM.
REQ-010 J  input  3  job index from JAM.
REQ-011 Cost  output  7  cost of (W,J), combinational.
REQ-012 MatchCount  input  4  JAM result.
REQ-013 MinCost  input  10  JAM result.
REQ-014 Valid  input  1  JAM result valid.
REQ-015 DONE  output  1  run finished.
REQ-016 PASS  output  1  results matched golden.
REQ-017 TIMEOUT  output  1  no Valid within TIMEOUT_CYC.
REQ-018 CYC_CNT  output  24  RUN-state cycle count.

Function
REQ-019 States LOAD, RSTJ, RUN, DONE; state after reset is LOAD.
REQ-020 LOAD: LD_READY=1, JAM_RST=1; accepted word k (k=0..63) writes LD_DATA[6:0] to cost entry k = 8*worker+job; word 64 writes gold MinCost (10 bits); word 65 writes gold MatchCount (LD_DATA[3:0]).
REQ-021 Load index increments only on accepted words; LD_VALID gaps hold index; after word 65 accepted, next state RSTJ.
REQ-022 LD_READY=0 in RSTJ, RUN, DONE; LD_VALID ignored there.
REQ-023 RSTJ: JAM_RST=1 for exactly HOLD_CYC cycles, then RUN.
REQ-024 RUN: JAM_RST=0; each edge CYC_CNT<=CYC_CNT+1; first RUN edge yields 1.
REQ-025 RUN edge with Valid=1: capture, PASS<=(MinCost==goldMin)&&(MatchCount==goldMatch), DONE<=1, go DONE.
REQ-026 RUN edge with Valid=0 and CYC_CNT+1==TIMEOUT_CYC: TIMEOUT<=1, PASS<=0, DONE<=1, go DONE.
REQ-027 Valid and timeout on same edge: Valid wins, TIMEOUT stays 0.
REQ-028 DONE: JAM_RST=1; DONE/PASS/TIMEOUT/CYC_CNT hold; Valid ignored; exit only via reset.
REQ-029 Cost = entry[{W,J}] combinationally in every state, including during LOAD (write visible next cycle).

Reset
REQ-030 RST=0 at an edge, in any state: state LOAD, load index 0, all 64 cost entries and both gold registers 0.
REQ-031 Outputs after reset: LD_READY=1, JAM_RST=1, Cost=0, DONE=0, PASS=0, TIMEOUT=0, CYC_CNT=0.
REQ-032 Reset mid-LOAD or mid-RUN discards partial progress; reload starts at word 0.

Verification
REQ-033 Load words k=0..63 value k, then 8, 1; set W=5,J=3 -> Cost=43; W=7,J=7 -> Cost=63.
REQ-034 Stub drives Valid on 5th RUN edge with MinCost=8, MatchCount=1 -> DONE=1, PASS=1, TIMEOUT=0, CYC_CNT=5, JAM_RST returns to 1.
REQ-035 Same, MinCost=9 -> DONE=1, PASS=0, TIMEOUT=0.
REQ-036 TIMEOUT_CYC=100, Valid never -> DONE=1, TIMEOUT=1, PASS=0, CYC_CNT=100; Valid at edge 100 instead -> PASS path, TIMEOUT=0.
REQ-037 Load with LD_VALID toggling every other cycle, RST=0 after 30 words -> Cost=0 all (W,J), LD_READY=1; full reload of 66 words then proceeds normally; JAM_RST high exactly HOLD_CYC=3 cycles in RSTJ.
